// File: rtl/booth_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : booth_issue_queue
// Purpose  : Operand FIFO and issue sequencer for the 7x7 signed Booth
//            multiplier. It also owns the multiplier's result register.
// Options  : BOOTH_ISSUE_WDOG_EN enables the WAIT-state watchdog (err flag).
// Revision : 1.0 - initial release
// ============================================================================
module booth_issue_queue #(
  parameter int DEPTH      = 4,
  parameter int WDOG_LIMIT = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               in_x,
  input  logic [6:0]               in_y,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     mul_start,
  output logic [6:0]               mul_x,
  output logic [6:0]               mul_y,
  input  logic                     mul_valid,
  input  logic [15:0]              mul_z,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_z,
  output logic                     err
);

  localparam int              c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [13:0]     r_mem [DEPTH];
  logic [c_AW:0]   r_wr_ptr;
  logic [c_AW:0]   r_rd_ptr;
  logic [c_AW:0]   w_level;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_free;
  logic            w_done;

  logic            r_mul_start;
  logic [6:0]      r_mul_x;
  logic [6:0]      r_mul_y;
  logic            r_out_valid;
  logic [15:0]     r_out_z;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == c_FULL);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = in_valid & ~w_full;
  assign w_free  = ~r_out_valid | out_ready;
  assign w_done  = (r_state == S_WAIT) & mul_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && w_free) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (mul_valid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mul_start <= 1'b0;
      r_mul_x     <= '0;
      r_mul_y     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mul_start <= w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr             <= r_rd_ptr + 1'b1;
        {r_mul_x, r_mul_y}   <= r_mem[r_rd_ptr[c_AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= {in_x, in_y};
  end

  // A load and an accept never coincide: out_valid is low for the whole multiply.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_z     <= '0;
    end else if (w_done) begin
      r_out_valid <= 1'b1;
      r_out_z     <= mul_z;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef BOOTH_ISSUE_WDOG_EN
  localparam int c_WW = $clog2(WDOG_LIMIT + 1);

  logic [c_WW-1:0] r_wdog_cnt;
  logic            r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wdog_cnt <= '0;
      r_err      <= 1'b0;
    end else if (r_state != S_WAIT || w_state_nxt != S_WAIT) begin
      r_wdog_cnt <= '0;
    end else if (r_wdog_cnt != c_WW'(WDOG_LIMIT)) begin
      r_wdog_cnt <= r_wdog_cnt + 1'b1;
      if (r_wdog_cnt == c_WW'(WDOG_LIMIT - 1)) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = ~w_full;
  assign level     = w_level;
  assign mul_start = r_mul_start;
  assign mul_x     = r_mul_x;
  assign mul_y     = r_mul_y;
  assign out_valid = r_out_valid;
  assign out_z     = r_out_z;

endmodule
`default_nettype wire

// File: tb/tb_booth_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_issue_queue
// Purpose  : Self-checking bench: directed vector table plus randomized
//            traffic compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_issue_queue;

  localparam int DEPTH      = 4;
  localparam int WDOG_LIMIT = 31;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [6:0]             in_x;
  logic [6:0]             in_y;
  logic [$clog2(DEPTH):0] level;
  logic                   mul_start;
  logic [6:0]             mul_x;
  logic [6:0]             mul_y;
  logic                   mul_valid;
  logic [15:0]            mul_z;
  logic                   out_valid;
  logic                   out_ready;
  logic [15:0]            out_z;
  logic                   err;

  always #5 clk = ~clk;

  booth_issue_queue #(.DEPTH(DEPTH), .WDOG_LIMIT(WDOG_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .level(level),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_valid(mul_valid), .mul_z(mul_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .err(err)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] prod(input logic [6:0] a, input logic [6:0] b);
    int ia;
    int ib;
    int p;
    ia = $signed(a);
    ib = $signed(b);
    p  = ia * ib;
    return p[15:0];
  endfunction

  // Multiplier stand-in: output pulse appears LAT edges after start is sampled.
  bit   mm_rand = 1'b0;
  bit   mm_hold = 1'b0;
  logic mm_valid;
  logic tb_inj;
  int   mm_rem;
  assign mul_valid = mm_valid | tb_inj;

  always @(posedge clk) begin
    if (!rst) begin
      mm_rem   <= 0;
      mm_valid <= 1'b0;
      mul_z    <= '0;
    end else begin
      mm_valid <= (mm_rem == 1) && !mm_hold;
      if (mul_start) begin
        mm_rem <= mm_rand ? int'($urandom_range(1, 12)) : 9;
        mul_z  <= prod(mul_x, mul_y);
      end else if (mm_rem != 0) begin
        mm_rem <= mm_rem - 1;
      end
    end
  end

  // Reference model: pending pairs in a queue, one multiply outstanding at most.
  typedef struct packed {
    logic [6:0] x;
    logic [6:0] y;
  } pair_t;

  pair_t       m_q[$];
  bit          m_busy  = 1'b0;
  bit          m_issue = 1'b0;
  pair_t       m_cur   = '0;
  bit          m_ov    = 1'b0;
  logic [15:0] m_z     = '0;
  bit          m_err   = 1'b0;
  int          m_wcnt  = 0;

  always @(posedge clk) begin
    bit waiting;
    bit done;
    bit free;
    bit pop;
    bit push;
    if (!rst) begin
      m_q.delete();
      m_busy  = 1'b0;
      m_issue = 1'b0;
      m_cur   = '0;
      m_ov    = 1'b0;
      m_z     = '0;
      m_err   = 1'b0;
      m_wcnt  = 0;
    end else begin
      waiting = m_busy && !m_issue;
      done    = waiting && mul_valid;
      free    = !m_ov || out_ready;
      pop     = !m_busy && (m_q.size() > 0) && free;
      push    = in_valid && (m_q.size() < DEPTH);
`ifdef BOOTH_ISSUE_WDOG_EN
      if (waiting && !mul_valid) begin
        m_wcnt++;
        if (m_wcnt >= WDOG_LIMIT) m_err = 1'b1;
      end else begin
        m_wcnt = 0;
      end
`endif
      if (pop) m_cur = m_q.pop_front();
      if (push) m_q.push_back({in_x, in_y});
      if (done) begin
        m_ov = 1'b1;
        m_z  = prod(m_cur.x, m_cur.y);
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      m_issue = pop;
      if (pop) m_busy = 1'b1;
      else if (done) m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_in_ready",  in_ready,  (m_q.size() < DEPTH));
      check("m_level",     level,     m_q.size());
      check("m_mul_start", mul_start, m_issue);
      check("m_mul_x",     mul_x,     m_cur.x);
      check("m_mul_y",     mul_y,     m_cur.y);
      check("m_out_valid", out_valid, m_ov);
      check("m_out_z",     out_z,     m_z);
      check("m_err",       err,       m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [6:0]  x;
    logic [6:0]  y;
    logic [15:0] z;
  } vec_t;

  vec_t vt[5];

  initial begin
    int w;
    vt[0] = '{x: 7'd5,      y: 7'd3,      z: 16'h000F};
    vt[1] = '{x: 7'(-4),    y: 7'd6,      z: 16'hFFE8};
    vt[2] = '{x: 7'(-64),   y: 7'(-64),   z: 16'h1000};
    vt[3] = '{x: 7'd63,     y: 7'(-64),   z: 16'hF040};
    vt[4] = '{x: 7'd0,      y: 7'd17,     z: 16'h0000};

    rst = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0;
    out_ready = 1'b0; tb_inj = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_in_ready",  in_ready,  1);
    check("rst_level",     level,     0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_x",     mul_x,     0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_z",     out_z,     0);
    check("rst_err",       err,       0);
    rst = 1'b1;

    // Single pair: start pulse after edge 1, out_valid from edge 12.
    in_valid = 1'b1; in_x = vt[0].x; in_y = vt[0].y;
    tick();
    in_valid = 1'b0;
    for (int n = 1; n <= 13; n++) begin
      tick();
      check("a_mul_start", mul_start, (n == 1));
      check("a_out_valid", out_valid, (n >= 12));
      check("a_mul_x",     mul_x,     vt[0].x);
      check("a_mul_y",     mul_y,     vt[0].y);
    end
    check("a_out_z", out_z, vt[0].z);

    // Result held: fill the FIFO behind it; nothing may issue.
    for (int i = 1; i < 5; i++) begin
      in_valid = 1'b1; in_x = vt[i].x; in_y = vt[i].y;
      tick();
    end
    in_valid = 1'b0;
    check("b_level_full", level,    4);
    check("b_in_ready",   in_ready, 0);
    repeat (5) begin
      tick();
      check("b_hold_start", mul_start, 0);
      check("b_hold_valid", out_valid, 1);
      check("b_hold_z",     out_z,     vt[0].z);
    end

    // Accept the result while pushing into the full FIFO: pop only.
    out_ready = 1'b1; in_valid = 1'b1; in_x = 7'd7; in_y = 7'd7;
    tick();
    in_valid = 1'b0;
    check("c_level_dec", level,     3);
    check("c_start",     mul_start, 1);
    check("c_mul_x",     mul_x,     vt[1].x);

    for (int i = 1; i < 5; i++) begin
      w = 0;
      while (!out_valid && w < 100) begin tick(); w++; end
      check("d_collect_timeout", (w < 100), 1);
      check("d_out_z", out_z, vt[i].z);
      tick();
    end
    repeat (20) tick();
    check("d_no_extra", out_valid, 0);
    check("d_empty",    level,     0);

    // Stalled multiplier: watchdog behaviour, then a late completion.
    mm_hold = 1'b1;
    in_valid = 1'b1; in_x = 7'd3; in_y = 7'(-2);
    tick();
    in_valid = 1'b0;
    repeat (40) tick();
`ifdef BOOTH_ISSUE_WDOG_EN
    check("e_err_set", err, 1);
`else
    check("e_err_zero", err, 0);
`endif
    check("e_stall_valid", out_valid, 0);
    tb_inj = 1'b1;
    tick();
    tb_inj = 1'b0;
    check("e_late_valid", out_valid, 1);
    check("e_late_z",     out_z,     16'hFFFA);
`ifdef BOOTH_ISSUE_WDOG_EN
    check("e_err_sticky", err, 1);
`else
    check("e_err_zero2", err, 0);
`endif
    tick();
    mm_hold = 1'b0;

    // Reset in WAIT, then a stray completion pulse.
    in_valid = 1'b1; in_x = 7'd10; in_y = 7'd10;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1; tb_inj = 1'b1;
    tick();
    tb_inj = 1'b0;
    tick();
    check("f_out_valid", out_valid, 0);
    check("f_out_z",     out_z,     0);
    check("f_mul_x",     mul_x,     0);
    check("f_mul_y",     mul_y,     0);
    check("f_level",     level,     0);
    check("f_in_ready",  in_ready,  1);
    check("f_err",       err,       0);

    // Randomized traffic, latencies, back-pressure, stray pulses and resets.
    mm_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      in_x      = 7'($urandom);
      in_y      = 7'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tb_inj    = (!m_busy || m_issue) && ($urandom_range(0, 15) == 0);
      tick();
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; tb_inj = 1'b0;
    w = 0;
    while ((m_q.size() != 0 || m_busy || m_ov) && w < 500) begin tick(); w++; end
    check("g_drain_timeout", (w < 500), 1);
    check("g_final_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
